// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg
// Shared types and constants for the reset sequencer:
//   seq_state_e - sequencer FSM states (ASSERT, RELEASE, RUN)
//   CNT_WIDTH   - width of the cycles-since-release counter
//   CNT_SAT     - value at which that counter saturates
//   cnt_width() - bit width needed to hold 0..max_val (never below 1)
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } seq_state_e;

  localparam int CNT_WIDTH = 32;
  localparam logic [CNT_WIDTH-1:0] CNT_SAT = 32'hFFFF_FFFF;

  // Width large enough to represent max_val itself, so counters compared
  // against (max_val - 1) never truncate at the top of the legal range.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/reset_seq_satcnt.sv
// reset_seq_satcnt
// 32-bit saturating up-counter.
// Ports:
//   clk   - clock
//   clr   - synchronous clear (wins over en)
//   en    - count enable; the count sticks at CNT_SAT instead of wrapping
//   count - registered count value
// The flop powers up at zero so the output is defined without any clear.
module reset_seq_satcnt
  import reset_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_q = '0;
  logic [CNT_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != CNT_SAT)) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer
// Generates NUM_STAGES staged, active-high synchronous resets. After the
// sequencer input reset goes high, every output stays asserted for
// HOLD_CYCLES cycles, then stage 0 releases, followed by each higher stage
// STAGE_GAP cycles after the previous one. Once the last stage is released
// the sequencer sits in RUN, flags rst_done and counts cycles spent there.
//
// Parameters:
//   HOLD_CYCLES - cycles all outputs stay asserted (1..65535)
//   NUM_STAGES  - number of staged reset outputs (1..8)
//   STAGE_GAP   - cycles between consecutive stage releases (1..255)
// Ports:
//   clk                  - the single clock
//   reset                - synchronous, active-low sequencer reset
//   rst_req              - re-reset request, honoured only in RUN
//   rst_ack              - one-cycle pulse when a re-reset request is taken
//   rst_out              - staged resets, bit i is stage i (active high)
//   rst_done             - high exactly while in RUN
//   cycles_since_release - saturating count of RUN cycles (0 on first one)
// Build option:
//   RESET_SEQ_REREQ_EN - when defined, rst_req restarts the sequence from
//   RUN; when undefined rst_req is ignored and rst_ack stays low.
//
// All flops carry declaration initial values equal to their reset values so
// the downstream resets are asserted from configuration onward.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 10,
  parameter int NUM_STAGES  = 2,
  parameter int STAGE_GAP   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rst_req,
  output logic                  rst_ack,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  rst_done,
  output logic [31:0]           cycles_since_release
);

`ifdef RESET_SEQ_REREQ_EN
  localparam bit REREQ_EN = 1'b1;
`else
  localparam bit REREQ_EN = 1'b0;
`endif

  localparam int HOLD_W  = cnt_width(HOLD_CYCLES);
  localparam int GAP_W   = cnt_width(STAGE_GAP);
  localparam int STAGE_W = cnt_width(NUM_STAGES);

  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(STAGE_GAP - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(NUM_STAGES - 1);

  seq_state_e            state_q     = ASSERT;
  logic [HOLD_W-1:0]     hold_cnt_q  = '0;
  logic [GAP_W-1:0]      gap_cnt_q   = '0;
  logic [STAGE_W-1:0]    stage_idx_q = '0;   // most recently released stage
  logic [NUM_STAGES-1:0] rst_out_q   = '1;
  logic                  rst_done_q  = 1'b0;
  logic                  rst_ack_q   = 1'b0;

  seq_state_e            state_d;
  logic [HOLD_W-1:0]     hold_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_d;
  logic [STAGE_W-1:0]    stage_idx_d;
  logic [NUM_STAGES-1:0] rst_out_d;
  logic                  rst_done_d;
  logic                  rst_ack_d;

  logic                  release_en;
  logic [STAGE_W-1:0]    release_idx;
  logic [STAGE_W-1:0]    stage_next;
  logic                  req_accept;
  logic [NUM_STAGES-1:0] release_mask;

  logic                  cnt_clr;
  logic                  cnt_en;
  logic [CNT_WIDTH-1:0]  cnt_value;

  assign stage_next = stage_idx_q + STAGE_W'(1);

  // Next-state logic. The reset input is applied in the register block.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    stage_idx_d = stage_idx_q;
    release_en  = 1'b0;
    release_idx = '0;
    req_accept  = 1'b0;

    case (state_q)
      ASSERT: begin
        if (hold_cnt_q == HOLD_LAST) begin
          // Hold time over: stage 0 goes low next cycle. A single-stage
          // build has nothing left to stagger and goes straight to RUN.
          hold_cnt_d  = '0;
          gap_cnt_d   = '0;
          stage_idx_d = '0;
          release_en  = 1'b1;
          release_idx = '0;
          state_d     = (NUM_STAGES == 1) ? RUN : RELEASE;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end

      RELEASE: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d   = '0;
          stage_idx_d = stage_next;
          release_en  = 1'b1;
          release_idx = stage_next;
          // RUN coincides with the cycle the last stage drops.
          if (stage_next == STAGE_LAST) begin
            state_d = RUN;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      RUN: begin
        req_accept = REREQ_EN && rst_req;
        if (req_accept) begin
          state_d     = ASSERT;
          hold_cnt_d  = '0;
          gap_cnt_d   = '0;
          stage_idx_d = '0;
        end
      end

      default: begin
        state_d     = ASSERT;
        hold_cnt_d  = '0;
        gap_cnt_d   = '0;
        stage_idx_d = '0;
      end
    endcase
  end

  // One-hot mask of the stage being released this cycle.
  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_release_mask
      assign release_mask[gi] = release_en && (release_idx == STAGE_W'(gi));
    end
  endgenerate

  // Stages only ever clear bits individually; the whole vector re-asserts
  // together on any return to ASSERT.
  always_comb begin
    rst_out_d  = rst_out_q & ~release_mask;
    if (state_d == ASSERT) begin
      rst_out_d = '1;
    end
    rst_done_d = (state_d == RUN);
    rst_ack_d  = req_accept;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ASSERT;
      hold_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      stage_idx_q <= '0;
      rst_out_q   <= '1;
      rst_done_q  <= 1'b0;
      rst_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      stage_idx_q <= stage_idx_d;
      rst_out_q   <= rst_out_d;
      rst_done_q  <= rst_done_d;
      rst_ack_q   <= rst_ack_d;
    end
  end

  // The counter is held at zero outside RUN, so its first RUN cycle reads 0
  // and it advances once for every cycle spent in RUN.
  assign cnt_clr = !reset || (state_d != RUN);
  assign cnt_en  = (state_q == RUN);

  reset_seq_satcnt u_satcnt (
    .clk   (clk),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cnt_value)
  );

  assign rst_out              = rst_out_q;
  assign rst_done             = rst_done_q;
  assign rst_ack              = rst_ack_q;
  assign cycles_since_release = cnt_value;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
// Directed bench for reset_sequencer at HOLD_CYCLES=10, NUM_STAGES=2,
// STAGE_GAP=4. Inputs change 1 time unit after the rising edge; outputs are
// sampled on the falling edge. Expected values follow the hand-derived
// timeline: rst_out=11 for sequence cycles 0-9, 10 for 10-13, 00 from 14,
// rst_done from 14, count = k-14 from 14.
// Build option: RESET_SEQ_REREQ_EN selects the re-reset expectations.
module tb_reset_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rst_req = 1'b0;
  logic        rst_ack;
  logic [1:0]  rst_out;
  logic        rst_done;
  logic [31:0] cycles_since_release;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .HOLD_CYCLES (10),
    .NUM_STAGES  (2),
    .STAGE_GAP   (4)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .rst_req              (rst_req),
    .rst_ack              (rst_ack),
    .rst_out              (rst_out),
    .rst_done             (rst_done),
    .cycles_since_release (cycles_since_release)
  );

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_out(input int k);
    if (k < 10)      return 2'b11;
    else if (k < 14) return 2'b10;
    else             return 2'b00;
  endfunction

  function automatic logic [31:0] exp_cnt(input int k);
    return (k >= 14) ? 32'(k - 14) : 32'd0;
  endfunction

  // Checks one cycle at sequence position k, then advances to 1 time unit
  // after the next rising edge, ready for the caller to drive inputs.
  task automatic cyc(input string tag, input int k, input logic ack_exp);
    string t;
    @(negedge clk);
    t = $sformatf("%s.k%0d", tag, k);
    $display("%s rst_out=%b done=%b cnt=%0d ack=%b", t, rst_out, rst_done,
             cycles_since_release, rst_ack);
    check_eq({t, ".rst_out"}, 32'(rst_out), 32'(exp_out(k)));
    check_eq({t, ".done"}, 32'(rst_done), 32'(k >= 14));
    check_eq({t, ".cnt"}, cycles_since_release, exp_cnt(k));
    check_eq({t, ".ack"}, 32'(rst_ack), 32'(ack_exp));
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Outputs asserted from time zero through initial flop values.
    #1;
    check_eq("init.rst_out", 32'(rst_out), 32'h3);
    check_eq("init.done", 32'(rst_done), 32'h0);

    // Power-up: reset low for three edges, then high.
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 20; k++) cyc("pwr", k, 1'b0);

    // Re-reset request pulse in RUN (cycle 20).
    rst_req = 1'b1;
    cyc("pwr", 20, 1'b0);
    rst_req = 1'b0;
`ifdef RESET_SEQ_REREQ_EN
    for (int k = 0; k < 16; k++) cyc("rereq", k, k == 0);
`else
    for (int k = 21; k < 37; k++) cyc("rereq", k, 1'b0);
`endif

    // Request during RELEASE is ignored.
    pulse_reset();
    for (int k = 0; k < 12; k++) cyc("relreq", k, 1'b0);
    rst_req = 1'b1;
    cyc("relreq", 12, 1'b0);
    rst_req = 1'b0;
    for (int k = 13; k < 21; k++) cyc("relreq", k, 1'b0);

    // Reset low mid-RELEASE for one cycle restarts the sequence.
    pulse_reset();
    for (int k = 0; k < 12; k++) cyc("midrst", k, 1'b0);
    reset = 1'b0;
    cyc("midrst", 12, 1'b0);
    reset = 1'b1;
    for (int k = 0; k < 15; k++) cyc("midrst2", k, 1'b0);

    // Held request: retriggers every time RUN is re-entered.
    pulse_reset();
    rst_req = 1'b1;
`ifdef RESET_SEQ_REREQ_EN
    for (int k = 0; k < 15; k++) cyc("held", k, 1'b0);
    cyc("held2", 0, 1'b1);
    for (int k = 1; k < 15; k++) cyc("held2", k, 1'b0);
    cyc("held3", 0, 1'b1);
    rst_req = 1'b0;
    for (int k = 1; k < 16; k++) cyc("held3", k, 1'b0);
`else
    for (int k = 0; k < 31; k++) cyc("held", k, 1'b0);
    rst_req = 1'b0;
`endif

    // Saturation: preload the counter just below the limit while in RUN.
    @(negedge clk);
    force dut.u_satcnt.count_q = 32'hFFFF_FFFD;
    #1;
    release dut.u_satcnt.count_q;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      $display("sat.i%0d cnt=%0h done=%b", i, cycles_since_release, rst_done);
      check_eq($sformatf("sat.i%0d.cnt", i), cycles_since_release,
               (i == 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
      check_eq($sformatf("sat.i%0d.done", i), 32'(rst_done), 32'h1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
